// File: rtl/spi_slave_port.sv
// SPI mode-0 responder with oversampled pins, one-word tx buffer and rx holding register.
// Define SPI_SLAVE_LSB_FIRST_EN to shift LSB first in both directions (default MSB first).

`ifndef W_CPU
`define W_CPU 32
`endif

module spi_slave_port #(
    parameter int W           = `W_CPU,
    parameter int SYNC_STAGES = 2,
    parameter bit CS_ACTIVE   = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         SPI_clk,
    input  logic         SPI_cs,
    input  logic         SPI_in,
    output logic         SPI_out,
    output logic         SPI_oe,
    output logic [W-1:0] rx_data,
    output logic         rx_valid,
    input  logic         rx_ack,
    output logic         rx_overrun,
    input  logic [W-1:0] tx_data,
    input  logic         tx_load,
    output logic         tx_ready,
    output logic         tx_underrun,
    output logic         frame_err,
    output logic         busy
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, din_sync, sync_fill;
    logic                   sclk_prev, sel_prev, armed;
    logic                   sclk_s, sel, din_s;
    logic                   sclk_rise, sclk_fall, cs_assert, cs_deassert;
    logic [CW-1:0]          bitcnt;
    logic [W-1:0]           tx_shift, rx_shift, tx_buf;
    logic                   tx_full, rx_done;
    logic                   fill, fill_from_buf, fill_bypass, fill_under, buf_write;
    logic                   rx_step, tx_step, word_done, ferr;
    logic [W-1:0]           fill_word, tx_shifted, rx_shifted;
    logic                   tx_bit;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign din_s  = din_sync[SYNC_STAGES-1];
    assign sel    = (cs_sync[SYNC_STAGES-1] == CS_ACTIVE);

    assign sclk_rise   = sclk_s & ~sclk_prev;
    assign sclk_fall   = ~sclk_s & sclk_prev;
    assign cs_assert   = sel & ~sel_prev & armed;
    assign cs_deassert = ~sel & sel_prev;

    // sync_fill marks when the chains hold real pin samples, so a CS held
    // active through reset is not mistaken for a fresh assert.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync <= '0;
            cs_sync   <= {SYNC_STAGES{~CS_ACTIVE}};
            din_sync  <= '0;
            sync_fill <= '0;
            sclk_prev <= 1'b0;
            sel_prev  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_cs};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], SPI_in};
            sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
            sel_prev  <= sel;
            if (sync_fill[SYNC_STAGES-1] && !sel)
                armed <= 1'b1;
        end
    end

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign tx_bit     = tx_shift[0];
    assign tx_shifted = {1'b0, tx_shift[W-1:1]};
    assign rx_shifted = {din_s, rx_shift[W-1:1]};
`else
    assign tx_bit     = tx_shift[W-1];
    assign tx_shifted = {tx_shift[W-2:0], 1'b0};
    assign rx_shifted = {rx_shift[W-2:0], din_s};
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cs_assert) state_nxt = LOAD;
            LOAD:    state_nxt = cs_deassert ? IDLE : SHIFT;
            SHIFT:   if (cs_deassert) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fill      = ((state == LOAD) && !cs_deassert) ||
                    ((state == SHIFT) && !cs_deassert && sclk_fall && (bitcnt == CW'(W)));
        rx_step   = (state == SHIFT) && !cs_deassert && sclk_rise;
        tx_step   = (state == SHIFT) && !cs_deassert && sclk_fall && (bitcnt < CW'(W));
        word_done = rx_step && (bitcnt == CW'(W - 1));
        ferr      = (state == SHIFT) && cs_deassert && (bitcnt != '0);

        fill_from_buf = fill && tx_full;
        fill_bypass   = fill && !tx_full && tx_load;
        fill_under    = fill && !tx_full && !tx_load;
        buf_write     = tx_load && !tx_full && !fill_bypass;

        fill_word = '0;
        if (tx_full)
            fill_word = tx_buf;
        else if (tx_load)
            fill_word = tx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            bitcnt      <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            rx_done     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rx_done     <= word_done;
            tx_underrun <= fill_under;
            frame_err   <= ferr;
            rx_overrun  <= 1'b0;

            if (fill || ((state != IDLE) && cs_deassert))
                bitcnt <= '0;
            else if (rx_step)
                bitcnt <= bitcnt + 1'b1;

            if (rx_step)
                rx_shift <= rx_shifted;

            if (fill)
                tx_shift <= fill_word;
            else if (tx_step)
                tx_shift <= tx_shifted;

            if (buf_write) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end else if (fill_from_buf) begin
                tx_full <= 1'b0;
            end

            // A completing word beats a same-cycle acknowledge.
            if (rx_done) begin
                rx_data    <= rx_shift;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~rx_ack;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign tx_ready = ~tx_full;
    assign busy     = (state != IDLE);
    assign SPI_oe   = busy;
    assign SPI_out  = (state == SHIFT) ? tx_bit : 1'b0;

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI responder (peripheral end) matching the CPU-side SPI master (MOSI transmitter / MISO receiver).
- Receives words shifted in on SPI_in and returns words on SPI_out, all in the system clk domain.
- SPI pins are oversampled through synchronizers.
- Used as the loopback/target device for SPI regfile verification, and as the SPI front-end for on-chip peripherals.

Parameters:
- W, `W_CPU (32): word length in bits per frame word.
- SYNC_STAGES, 2: flip-flop stages on SPI_clk, SPI_cs and SPI_in (minimum 2).
- CS_ACTIVE, 0: level of SPI_cs that selects this device.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-low reset.
- SPI_clk  input  1  serial clock from master; idle low (mode 0); frequency at most clk/4.
- SPI_cs  input  1  chip select; active at CS_ACTIVE.
- SPI_in  input  1  master-out data.
- SPI_out  output  1  master-in data.
- SPI_oe  output  1  high while selected; external pad enable.
- rx_data  output  W  last complete received word.
- rx_valid  output  1  level; rx_data holds an unacknowledged word.
- rx_ack  input  1  consumer acknowledge; clears rx_valid.
- rx_overrun  output  1  one-cycle pulse; a new word overwrote an unacknowledged one.
- tx_data  input  W  word to return to master.
- tx_load  input  1  write tx_data into the tx buffer.
- tx_ready  output  1  tx buffer empty.
- tx_underrun  output  1  one-cycle pulse; a word started with an empty buffer.
- frame_err  output  1  one-cycle pulse; CS released mid-word.
- busy  output  1  high in LOAD/SHIFT.

Behaviour:
- Reset (rst==0 at posedge clk), all outputs:
  - SPI_out=0, SPI_oe=0, rx_data=0, rx_valid=0, rx_overrun=0, tx_ready=1, tx_underrun=0, frame_err=0, busy=0.
  - Synchronizers are cleared to idle: SPI_clk=0, SPI_cs=!CS_ACTIVE.
  - Bit counter=0, state=IDLE.
  - A reset mid-frame discards the partial word and the tx buffer; the device stays IDLE until CS is seen inactive then active again.
- Edge detect: the synchronized SPI_clk is registered once more. rise = sync & !prev, fall = !sync & prev. CS assert and deassert are detected the same way.
- FSM:
  - IDLE: SPI_oe=0, SPI_out=0. On CS assert -> LOAD.
  - LOAD (1 cycle): fill shift register (rules below), drive SPI_out = shift MSB, SPI_oe=1 -> SHIFT.
  - SHIFT, on rise: shift the synchronized SPI_in into the rx shift LSB; bitcnt++.
  - SHIFT, on fall with bitcnt<W: shift tx left; SPI_out = new MSB.
  - SHIFT, on fall with bitcnt==W: bitcnt=0; refill shift register (same rules as LOAD); stay in SHIFT (back-to-back words).
  - SHIFT, on rise bringing bitcnt to W: next cycle rx_data = rx shift value and rx_valid=1. If rx_valid was already 1 and not acked that same cycle, rx_overrun pulses and rx_data is still overwritten.
  - SHIFT, on CS deassert: if bitcnt!=0, frame_err pulses and the partial word is discarded (no rx_valid) -> IDLE.
- Shift-register fill rules:
  - If the tx buffer is full: shift = buffer; buffer empties; tx_ready=1 next cycle.
  - If the buffer is empty and tx_load is asserted the same cycle: shift = tx_data directly (bypass); tx_ready stays 1.
  - Otherwise: shift = 0 and tx_underrun pulses.
- tx handshake: tx_load is accepted only when tx_ready=1; the buffer is written and tx_ready=0 next cycle. tx_load with tx_ready=0 is ignored.
- rx handshake: rx_ack with rx_valid=1 clears rx_valid next cycle. If rx_ack coincides with a new word completing, the new word wins: rx_valid stays 1 and there is no overrun.
- Latency: rx_valid is set SYNC_STAGES+2 clk cycles after the pin-level SCLK rise carrying bit W-1.
- Bit order: MSB first, both directions.
- rise and fall in the same cycle cannot occur; rise with CS deassert in the same cycle: the deassert wins.

Optional Feature:
- Macro SPI_SLAVE_LSB_FIRST_EN.
- Defined: both directions LSB first; rx shifts in at the MSB and shifts right; SPI_out drives the shift LSB and tx shifts right.
- Undefined: MSB first as specified above. Handshakes and timing are identical either way.

Test Plan:
- Reset, then master sends 0xA5A5F00D with CS held for 32 SCLKs -> rx_valid=1, rx_data=0xA5A5F00D; frame_err=0.
- tx_load 0xDEADBEEF before CS; master clocks 32 bits -> master captures 0xDEADBEEF; tx_ready returns to 1 on LOAD+1; tx_underrun=0.
- Back-to-back frame without CS release: buffer 0x11111111, then load 0x22222222 during word 1 -> master receives both in order; two rx_valid events each acked.
- CS released after 10 SCLKs -> frame_err pulse, rx_valid stays 0; next full frame 0x12345678 received correctly.
- Two words with no rx_ack -> rx_overrun pulse once, rx_data = second word. Empty buffer at word start -> SPI_out=0 for 32 bits and tx_underrun pulse.
- rst=0 asserted at bit 16 with CS still active -> all outputs at reset values; no rx_valid until CS toggles inactive/active and a full frame is sent.
